// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter that shares one cache port among NUM_CORES cores.
// Ports: req/rw_core/address_core from the cores, hit from the cache.
// gnt and hit_core go back to the cores, cache_* go to the cache.
// owner_id reports the current or last owner; timeout_err pulses on forced release.
module cache_bus_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12,
    parameter int TIMEOUT   = 64,
    localparam int ID_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        rw_core,
    input  logic [NUM_CORES*ADDR_W-1:0] address_core,
    input  logic                        hit,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        hit_core,
    output logic                        cache_valid,
    output logic                        cache_rw,
    output logic [ADDR_W-1:0]           cache_address,
    output logic [ID_W-1:0]             owner_id,
    output logic                        timeout_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [NUM_CORES-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      owner_id_q, owner_id_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                 timeout_err_q, timeout_err_d;

    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      next_ptr;

    // Scan from the highest offset down so the core closest to rr_ptr
    // is the last one written, i.e. it wins.
    always_comb begin
        int unsigned idx;
        winner = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_CORES;
            if (req[idx]) begin
                winner = ID_W'(idx);
            end
        end
    end

    assign next_ptr = (int'(owner_id_q) == NUM_CORES - 1)
                    ? '0 : ID_W'(int'(owner_id_q) + 1);

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        rr_ptr_d      = rr_ptr_q;
        owner_id_d    = owner_id_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d         = '0;
                    gnt_d[winner] = 1'b1;
                    owner_id_d    = winner;
                    hold_cnt_d    = '0;
                    state_d       = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Only the owner's request bit is consulted here, so
                // non-owner requests (even unknown) cannot disturb the bus.
                if (!req[owner_id_q]) begin
                    gnt_d    = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_RELEASE;
                end else if (hold_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    gnt_d         = '0;
                    rr_ptr_d      = next_ptr;
                    state_d       = ST_RELEASE;
                    timeout_err_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                // Turnaround cycle for the shared data bus.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            rr_ptr_q      <= '0;
            owner_id_q    <= '0;
            hold_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_id_q    <= owner_id_d;
            hold_cnt_q    <= hold_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Bus muxes are combinational off the registered owner, so an
    // asynchronous reset drops cache_valid in the same cycle.
    always_comb begin
        cache_valid   = 1'b0;
        cache_rw      = 1'b0;
        cache_address = '0;
        hit_core      = '0;
        if (state_q == ST_GRANT) begin
            cache_valid          = req[owner_id_q];
            cache_rw             = rw_core[owner_id_q];
            cache_address        =
                address_core[int'(owner_id_q)*ADDR_W +: ADDR_W];
            hit_core[owner_id_q] = hit;
        end
    end

    assign gnt         = gnt_q;
    assign owner_id    = owner_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Testbench for cache_bus_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_cache_bus_arbiter;

    localparam int NC = 4;
    localparam int AW = 12;
    localparam int TO = 8;

    logic          clk;
    logic          rst;
    logic [NC-1:0] req;
    logic [NC-1:0] rw_core;
    logic [NC*AW-1:0] address_core;
    logic          hit;
    logic [NC-1:0] gnt;
    logic [NC-1:0] hit_core;
    logic          cache_valid;
    logic          cache_rw;
    logic [AW-1:0] cache_address;
    logic [1:0]    owner_id;
    logic          timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    cache_bus_arbiter #(
        .NUM_CORES(NC),
        .ADDR_W   (AW),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .rw_core      (rw_core),
        .address_core (address_core),
        .hit          (hit),
        .gnt          (gnt),
        .hit_core     (hit_core),
        .cache_valid  (cache_valid),
        .cache_rw     (cache_rw),
        .cache_address(cache_address),
        .owner_id     (owner_id),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who holds the bus, for how long, and whether the
    // turnaround cycle is still pending.
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_gap   = 0;
    bit m_terr  = 0;

    always @(posedge clk or posedge rst) begin : model
        int o, p, h, g, l, w;
        bit te;
        if (rst) begin
            m_owner <= -1;
            m_last  <= 0;
            m_ptr   <= 0;
            m_held  <= 0;
            m_gap   <= 0;
            m_terr  <= 0;
        end else begin
            o = m_owner; p = m_ptr; h = m_held;
            g = m_gap; l = m_last; te = 0;
            if (o >= 0) begin
                h = h + 1;
                if (req[o] !== 1'b1 || h == TO) begin
                    te = (req[o] === 1'b1);
                    p  = (o + 1) % NC;
                    o  = -1;
                    g  = 1;
                end
            end else if (g != 0) begin
                g = 0;
            end else begin
                w = -1;
                for (int k = 0; k < NC; k++)
                    if (w < 0 && req[(p + k) % NC] === 1'b1)
                        w = (p + k) % NC;
                if (w >= 0) begin
                    o = w; l = w; h = 0;
                end
            end
            m_owner <= o;
            m_ptr   <= p;
            m_held  <= h;
            m_gap   <= g;
            m_last  <= l;
            m_terr  <= te;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        rw_core = '0;
        address_core = '0;
        hit = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({gnt, hit_core, cache_valid, cache_rw, cache_address,
             owner_id, timeout_err} !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 0",
                {gnt, hit_core, cache_valid, cache_rw, cache_address,
                 owner_id, timeout_err});
        end
        rst = 1'b0;
        req = 4'b0001;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_pregrant: gnt %b want 0001", gnt);
        end
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000 || cache_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: gnt %b valid %b want 0000 0",
                gnt, cache_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0100;
        tick();
        n_cmp++;
        if (gnt !== 4'b0100 || owner_id !== 2'd2) begin
            n_bad++;
            $display("FAIL reset_regrant: gnt %b id %0d want 0100 2",
                gnt, owner_id);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_single();
        req = 4'b0010;
        rw_core = 4'b0010;
        address_core = {$urandom, $urandom};
        address_core[1*AW +: AW] = 12'hA5C;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010 || cache_address !== 12'hA5C ||
            cache_rw !== 1'b1 || cache_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_grant: gnt %b a %h rw %b v %b want 0010 a5c 1 1",
                gnt, cache_address, cache_rw, cache_valid);
        end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL single_hold: gnt %b want 0010", gnt);
        end
        req = '0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || cache_valid !== 1'b0 ||
            cache_address !== 12'h000) begin
            n_bad++;
            $display("FAIL single_release: gnt %b v %b a %h want 0 0 0",
                gnt, cache_valid, cache_address);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || owner_id !== 2'd1) begin
            n_bad++;
            $display("FAIL single_idle: gnt %b id %0d want 0000 1",
                gnt, owner_id);
        end
    endtask

    task automatic test_round_robin();
        int grants, held, gap, cur;
        reset_pulse();
        req = 4'b1111;
        grants = 0; held = 0; gap = 0; cur = -1;
        for (int c = 0; c < 80 && grants < 5; c++) begin
            tick();
            if (gnt !== 4'b0000) begin
                if (held == 0) begin
                    cur = -1;
                    for (int i = 0; i < NC; i++)
                        if (gnt[i] === 1'b1) cur = i;
                    n_cmp++;
                    if (cur != grants % NC) begin
                        n_bad++;
                        $display("FAIL rr_order: grant %0d to %0d want %0d",
                            grants, cur, grants % NC);
                    end
                    if (grants > 0) begin
                        n_cmp++;
                        if (gap != 2) begin
                            n_bad++;
                            $display("FAIL rr_gap: gap %0d want 2", gap);
                        end
                    end
                    grants++;
                end
                held++;
                gap = 0;
                if (held == 3 && cur >= 0) req[cur] = 1'b0;
            end else begin
                held = 0;
                gap++;
                req = 4'b1111;
            end
        end
        n_cmp++;
        if (grants != 5) begin
            n_bad++;
            $display("FAIL rr_timeout: saw %0d grants want 5", grants);
        end
        req = '0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_wrap();
        reset_pulse();
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        req = 4'b0011;
        tick();
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL wrap_first: gnt %b want 0001", gnt);
        end
        req = 4'b0010;
        tick();
        tick();
        tick();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++;
            $display("FAIL wrap_second: gnt %b want 0010", gnt);
        end
        req = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int cnt, nt;
        bit seen;
        cnt = 0; nt = 0; seen = 0;
        req = 4'b0100;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (gnt === 4'b0100) cnt++;
            if (timeout_err === 1'b1) nt++;
            if (gnt === 4'b0000 && cnt > 0) begin
                seen = 1;
                n_cmp++;
                if (timeout_err !== 1'b1) begin
                    n_bad++;
                    $display("FAIL to_pulse: terr %b want 1", timeout_err);
                end
                req = 4'b0101;
            end
        end
        n_cmp++;
        if (cnt != TO || nt != 1 || !seen) begin
            n_bad++;
            $display("FAIL to_len: cycles %0d pulses %0d want %0d 1",
                cnt, nt, TO);
        end
        tick();
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL to_once: terr %b want 0", timeout_err);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL to_next: gnt %b want 0001", gnt);
        end
        req = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_hit();
        req = 4'b1000;
        hit = 1'b0;
        tick();
        hit = 1'b1;
        #1;
        n_cmp++;
        if (hit_core !== 4'b1000 || owner_id !== 2'd3) begin
            n_bad++;
            $display("FAIL hit_owner: hit_core %b id %0d want 1000 3",
                hit_core, owner_id);
        end
        @(negedge clk);
        req = '0;
        tick();
        n_cmp++;
        if (hit_core !== 4'b0000) begin
            n_bad++;
            $display("FAIL hit_release: hit_core %b want 0000", hit_core);
        end
        hit = 1'b0;
        tick();
    endtask

    task automatic test_xreq();
        req = 4'b0010;
        tick();
        req = 4'bxx1x;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b0010 || cache_valid !== 1'b1 ||
                timeout_err !== 1'b0) begin
                n_bad++;
                $display("FAIL xreq: gnt %b v %b terr %b want 0010 1 0",
                    gnt, cache_valid, timeout_err);
            end
        end
        req = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [NC-1:0] e_gnt, e_hit;
        logic          e_v, e_rw;
        logic [AW-1:0] e_a;
        reset_pulse();
        for (int c = 0; c < 400; c++) begin
            e_gnt = '0; e_hit = '0; e_v = 0; e_rw = 0; e_a = '0;
            if (m_owner >= 0) begin
                e_gnt[m_owner] = 1'b1;
                e_v  = req[m_owner];
                e_rw = rw_core[m_owner];
                e_a  = address_core[m_owner*AW +: AW];
                e_hit[m_owner] = hit;
            end
            n_cmp++;
            if ({gnt, hit_core, cache_valid, cache_rw, cache_address,
                 owner_id, timeout_err} !==
                {e_gnt, e_hit, e_v, e_rw, e_a, 2'(m_last), m_terr}) begin
                n_bad++;
                $display("FAIL rand cyc %0d: got %h want %h", c,
                    {gnt, hit_core, cache_valid, cache_rw, cache_address,
                     owner_id, timeout_err},
                    {e_gnt, e_hit, e_v, e_rw, e_a, 2'(m_last), m_terr});
            end
            for (int i = 0; i < NC; i++) begin
                if (req[i]) begin
                    if ($urandom_range(5) == 0) req[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                end
            end
            rw_core = NC'($urandom);
            address_core = {$urandom, $urandom};
            hit = 1'($urandom);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        rw_core = '0;
        address_core = '0;
        hit = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_hit();
        test_xreq();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
            n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
